mult_div_unit: RTL and testbench

//   Multi-cycle multiply/divide unit for the P6 pipelined MIPS core. It sits in EX

---
 rtl/mult_div_unit_if.sv | 14 +
 rtl/mult_div_unit.sv | 96 +++++++++
 tb/tb_mult_div_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand/command and result bundle between the EX stage and the multiply/divide unit.
// The master side drives the command and operands; the slave side returns busy and HI/LO.
interface mult_div_unit_if;
   logic        start;
   logic [2:0]  MDop;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, MDop, A, B, input busy, HI, LO);
   modport slave  (input start, MDop, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle mult/multu/div/divu plus mthi/mtlo into HI/LO; result lands N cycles after launch.
// No backpressure: busy tells the hazard unit to hold MD instructions; commands while busy are dropped.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   mult_div_unit_if.slave md
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   a_q, b_q, hi_q, lo_q;
   logic          sgn_q, busy_q;

   logic [63:0]   a_ext, b_ext, prod_d;
   logic [31:0]   a_mag, b_mag, b_nz, q_mag, r_mag, quo_d, rem_d;
   logic          b_zero;

   // Signed ops are done on magnitudes and fixed up afterwards; this also yields
   // 0x80000000 / -1 -> quotient 0x80000000, remainder 0 with no special case.
   always_comb begin
      a_ext  = {{32{sgn_q & a_q[31]}}, a_q};
      b_ext  = {{32{sgn_q & b_q[31]}}, b_q};
      prod_d = a_ext * b_ext;
      a_mag  = (sgn_q && a_q[31]) ? -a_q : a_q;
      b_mag  = (sgn_q && b_q[31]) ? -b_q : b_q;
      b_zero = (b_q == 32'd0);
      b_nz   = b_zero ? 32'd1 : b_mag;
      q_mag  = a_mag / b_nz;
      r_mag  = a_mag % b_nz;
      quo_d  = (sgn_q && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
      rem_d  = (sgn_q && a_q[31]) ? -r_mag : r_mag;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (md.start && (md.MDop <= 3'd3)) begin
                  a_q    <= md.A;
                  b_q    <= md.B;
                  sgn_q  <= ~md.MDop[0];
                  busy_q <= 1'b1;
                  if (md.MDop[1]) begin
                     state_q <= DIV;
                     cnt_q   <= CW'(DIV_CYCLES);
                  end else begin
                     state_q <= MULT;
                     cnt_q   <= CW'(MULT_CYCLES);
                  end
               end else if (md.MDop == 3'd4) begin
                  hi_q <= md.A;
               end else if (md.MDop == 3'd5) begin
                  lo_q <= md.A;
               end
            end
            MULT, DIV: begin
               if (cnt_q == CW'(1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  if (state_q == MULT) begin
                     hi_q <= prod_d[63:32];
                     lo_q <= prod_d[31:0];
                  end else if (!b_zero) begin
                     hi_q <= rem_d;
                     lo_q <= quo_d;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign md.busy = busy_q;
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: stimulus pushes expected HI/LO and busy length into a queue,
// a monitor pops and compares each time busy falls.
module tb_mult_div_unit;
   logic clk = 1'b0;
   logic reset;
   mult_div_unit_if md ();

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: counts busy cycles and checks the result on the cycle busy drops.
   int   busy_cnt  = 0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      if (md.busy === 1'b1) begin
         busy_cnt++;
      end else if (prev_busy) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: busy fell with no expected entry, HI=0x%08h LO=0x%08h", md.HI, md.LO);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_hi"}, md.HI, e.hi);
            check({e.name, "_lo"}, md.LO, e.lo);
            check({e.name, "_cycles"}, 32'(busy_cnt), 32'(e.cycles));
         end
         busy_cnt = 0;
      end
      prev_busy = (md.busy === 1'b1);
   end

   task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo, input int cycles);
      exp_t e;
      e.name = name; e.hi = hi; e.lo = lo; e.cycles = cycles;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 after the launch edge with operands scrambled.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      md.start = 1'b1; md.MDop = op; md.A = a; md.B = b;
      @(posedge clk); #1;
      md.start = 1'b0; md.MDop = 3'd7; md.A = $urandom(); md.B = $urandom();
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100; i++) begin
         if (md.busy === 1'b0) return;
         @(posedge clk); #1;
      end
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy still 1 after 100 cycles, expected 0", name);
   endtask

   initial begin
      reset = 1'b1;
      md.start = 1'b0; md.MDop = 3'd7; md.A = '0; md.B = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_hi", md.HI, 32'h0);
      check("reset_lo", md.LO, 32'h0);
      check("reset_busy", 32'(md.busy), 32'd0);

      // Signed and unsigned multiply
      push("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      issue(3'd0, 32'hFFFFFFFE, 32'd3);
      check("mult_busy_after_launch", 32'(md.busy), 32'd1);
      wait_idle("mult_neg");
      push("multu_max", 32'hFFFFFFFE, 32'h00000001, 5);
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle("multu_max");

      // Divide variants
      push("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue(3'd2, 32'hFFFFFFF9, 32'd2);
      wait_idle("div_neg");
      push("divu", 32'h00000001, 32'h7FFFFFFC, 10);
      issue(3'd3, 32'hFFFFFFF9, 32'd2);
      wait_idle("divu");
      push("div_negdivisor", 32'h00000001, 32'hFFFFFFFD, 10);
      issue(3'd2, 32'd7, 32'hFFFFFFFE);
      wait_idle("div_negdivisor");
      push("div_ovf", 32'h00000000, 32'h80000000, 10);
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_idle("div_ovf");

      // mthi / mtlo take effect on the next edge, no busy
      md.MDop = 3'd4; md.A = 32'h12345678;
      @(posedge clk); #1;
      check("mthi_hi", md.HI, 32'h12345678);
      check("mthi_busy", 32'(md.busy), 32'd0);
      md.MDop = 3'd5; md.A = 32'h9ABCDEF0;
      @(posedge clk); #1;
      check("mtlo_lo", md.LO, 32'h9ABCDEF0);
      check("mtlo_hi_kept", md.HI, 32'h12345678);
      check("mtlo_busy", 32'(md.busy), 32'd0);
      md.MDop = 3'd7;

      // start with a non-launch opcode is a no-op
      md.start = 1'b1; md.MDop = 3'd6; md.A = 32'h55555555; md.B = 32'd1;
      @(posedge clk); #1;
      md.start = 1'b0; md.MDop = 3'd7;
      check("noop_busy", 32'(md.busy), 32'd0);
      check("noop_hi", md.HI, 32'h12345678);

      // Divide by zero keeps HI/LO
      push("div_by_zero", 32'h12345678, 32'h9ABCDEF0, 10);
      issue(3'd2, 32'd100, 32'd0);
      wait_idle("div_by_zero");
      push("divu_by_zero", 32'h12345678, 32'h9ABCDEF0, 10);
      issue(3'd3, 32'hFFFFFFFF, 32'd0);
      wait_idle("divu_by_zero");

      // Reset during busy cycle 4 aborts the divide
      push("reset_abort", 32'h0, 32'h0, 4);
      issue(3'd2, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", 32'(md.busy), 32'd0);
      repeat (12) @(posedge clk);
      #1;
      check("abort_no_late_hi", md.HI, 32'h0);
      check("abort_no_late_lo", md.LO, 32'h0);

      // start and mtlo while busy are ignored
      push("ignore_while_busy", 32'h0, 32'd42, 5);
      issue(3'd0, 32'd7, 32'd6);
      md.start = 1'b1; md.MDop = 3'd2; md.A = 32'd1000; md.B = 32'd3;
      @(posedge clk); #1;
      md.start = 1'b0; md.MDop = 3'd5; md.A = 32'hDEADBEEF;
      @(posedge clk); #1;
      md.MDop = 3'd7;
      wait_idle("ignore_while_busy");
      repeat (12) @(posedge clk);
      #1;
      check("ignore_still_idle", 32'(md.busy), 32'd0);
      check("ignore_lo_kept", md.LO, 32'd42);

      // Back-to-back launch on the first idle cycle
      push("b2b_mult", 32'h0, 32'd12, 5);
      issue(3'd0, 32'd3, 32'd4);
      wait_idle("b2b_mult");
      push("b2b_multu", 32'h0, 32'd30, 5);
      issue(3'd1, 32'd5, 32'd6);
      check("b2b_second_busy", 32'(md.busy), 32'd1);
      wait_idle("b2b_multu");

      repeat (3) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
